// File: rtl/core_debug_tx.sv
// ============================================================================
// Module   : core_debug_tx
// Brief    : Snapshots core state (PC, IR, flags, R0..R7) and streams it as a
//            21-byte 8N1 serial frame for the lab host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_debug_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        snap,
    input  logic [7:0]  PC,
    input  logic [15:0] IRout,
    input  logic        Cout,
    input  logic        Z,
    input  logic        N,
    input  logic [15:0] R0,
    input  logic [15:0] R1,
    input  logic [15:0] R2,
    input  logic [15:0] R3,
    input  logic [15:0] R4,
    input  logic [15:0] R5,
    input  logic [15:0] R6,
    input  logic [15:0] R7,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int              BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int              FRAME_BYTES = 21;
    localparam logic [4:0]      LAST_IDX    = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [4:0]          r_idx, w_idx_nxt;
    logic [2:0]          r_bit, w_bit_nxt;
    logic [BAUD_W-1:0]   r_baud, w_baud_nxt;
    logic                r_tx, w_tx_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_load;
    logic                w_bit_end;
    logic [7:0]          w_cur_byte;

    logic [7:0]          r_shadow [FRAME_BYTES];
    logic [7:0]          w_frame  [FRAME_BYTES];
    logic [15:0]         w_regs   [8];

    assign w_regs = '{R0, R1, R2, R3, R4, R5, R6, R7};

    assign w_frame[0] = HEADER;
    assign w_frame[1] = PC;
    assign w_frame[2] = IRout[15:8];
    assign w_frame[3] = IRout[7:0];
    assign w_frame[4] = {5'b0, Cout, Z, N};

    // Registers are sent big-endian, two bytes each, starting at index 5.
    for (genvar k = 0; k < 8; k++) begin : g_reg_bytes
        assign w_frame[5 + 2*k] = w_regs[k][15:8];
        assign w_frame[6 + 2*k] = w_regs[k][7:0];
    end

    assign w_bit_end  = (r_baud == BAUD_LAST);
    assign w_cur_byte = r_shadow[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bit_nxt   = r_bit;
        w_baud_nxt  = r_baud;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (snap) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_busy_nxt  = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_idx_nxt   = 5'd0;
                    w_bit_nxt   = 3'd0;
                    w_baud_nxt  = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = w_cur_byte[0];
                end else begin
                    w_baud_nxt  = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = w_cur_byte[r_bit + 3'd1];
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = 5'd0;
                    end else begin
                        w_state_nxt = S_START;
                        w_idx_nxt   = r_idx + 5'd1;
                        w_tx_nxt    = 1'b0;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
            r_bit   <= 3'd0;
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bit   <= w_bit_nxt;
            r_baud  <= w_baud_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The shadow only matters once a frame is accepted, so it carries no reset.
    always_ff @(posedge clock_50) begin
        if (w_load && !reset) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                r_shadow[i] <= w_frame[i];
            end
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_core_debug_tx.sv
// ============================================================================
// Module   : tb_core_debug_tx
// Brief    : Scoreboard bench for core_debug_tx with an 8N1 receiver model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_debug_tx;

    localparam int CPB = 4;

    logic        clock_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        snap     = 1'b0;
    logic [7:0]  pc       = '0;
    logic [15:0] ir       = '0;
    logic        cout     = 1'b0;
    logic        z        = 1'b0;
    logic        n        = 1'b0;
    logic [15:0] rv [8];
    logic        tx, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc     = 0;
    logic [7:0] sb [$];

    core_debug_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .snap     (snap),
        .PC       (pc),
        .IRout    (ir),
        .Cout     (cout),
        .Z        (z),
        .N        (n),
        .R0       (rv[0]),
        .R1       (rv[1]),
        .R2       (rv[2]),
        .R3       (rv[3]),
        .R4       (rv[4]),
        .R5       (rv[5]),
        .R6       (rv[6]),
        .R7       (rv[7]),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock_50 = ~clock_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock_50);
        #1;
        cyc++;
    endtask

    task automatic push_frame();
        sb.push_back(8'hA5);
        sb.push_back(pc);
        sb.push_back(ir[15:8]);
        sb.push_back(ir[7:0]);
        sb.push_back({5'b0, cout, z, n});
        for (int k = 0; k < 8; k++) begin
            sb.push_back(rv[k][15:8]);
            sb.push_back(rv[k][7:0]);
        end
    endtask

    task automatic set_fixed();
        pc = 8'h12; ir = 16'hBEEF; cout = 1'b1; z = 1'b0; n = 1'b1;
        for (int k = 0; k < 8; k++) rv[k] = 16'h1000 + 16'(k);
    endtask

    task automatic set_random();
        pc = 8'($urandom); ir = 16'($urandom);
        cout = 1'($urandom); z = 1'($urandom); n = 1'($urandom);
        for (int k = 0; k < 8; k++) rv[k] = 16'($urandom);
    endtask

    task automatic snap_frame();
        snap = 1'b1;
        push_frame();
        tick();
        acc  = cyc;
        snap = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_tx", tx, 0);
    endtask

    // Waits for done, checks latency and that it is a single-cycle pulse.
    task automatic wait_done();
        int k = 0;
        while (!done && k < 2000) begin
            tick();
            k++;
        end
        check("done_seen", done, 1);
        check("done_lat", cyc - acc, 210 * CPB);
        check("done_busy", busy, 0);
        check("done_tx", tx, 1);
        tick();
        check("done_pulse", done, 0);
    endtask

    // Serial receiver: samples every cycle, verifies each bit level is held
    // CPB cycles, bytes are back-to-back inside a frame, and data matches.
    logic       m_active     = 1'b0;
    logic       m_need_start = 1'b0;
    logic       m_lv         = 1'b0;
    logic       m_stable     = 1'b1;
    logic [7:0] m_byte       = '0;
    logic [7:0] m_exp;
    int         m_bit = 0, m_s = 0, m_fbyte = 0;

    always @(negedge clock_50) begin
        if (reset) begin
            m_active     = 1'b0;
            m_need_start = 1'b0;
            m_fbyte      = 0;
            sb.delete();
        end else if (!m_active) begin
            if (m_need_start) begin
                check("byte_gap", tx, 0);
                m_need_start = 1'b0;
            end
            if (tx == 1'b0) begin
                m_active = 1'b1;
                m_bit    = 0;
                m_s      = 1;
                m_lv     = 1'b0;
                m_stable = 1'b1;
            end
        end else begin
            if (m_s == 0) begin
                m_lv     = tx;
                m_stable = 1'b1;
            end else if (tx !== m_lv) begin
                m_stable = 1'b0;
            end
            m_s++;
            if (m_s == CPB) begin
                check("bit_width", m_stable, 1);
                if (m_bit >= 1 && m_bit <= 8) begin
                    m_byte[m_bit-1] = m_lv;
                end else if (m_bit == 9) begin
                    check("stop_bit", m_lv, 1);
                    if (sb.size() == 0) begin
                        check("rx_extra", {24'h0, m_byte}, 32'h100);
                    end else begin
                        m_exp = sb.pop_front();
                        check("rx_byte", m_byte, m_exp);
                    end
                    m_active     = 1'b0;
                    m_fbyte      = (m_fbyte == 20) ? 0 : m_fbyte + 1;
                    m_need_start = (m_fbyte != 0);
                end
                m_bit++;
                m_s = 0;
            end
        end
    end

    initial begin
        logic seen;
        for (int k = 0; k < 8; k++) rv[k] = '0;

        // Reset, with a snap that must be ignored while reset is high.
        reset = 1'b1;
        snap  = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        snap  = 1'b0;
        reset = 1'b0;
        seen  = 1'b0;
        repeat (50) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
        end
        check("idle_quiet", seen, 0);

        // Known frame.
        set_fixed();
        snap_frame();
        wait_done();

        // Inputs cleared right after accept must not disturb the frame.
        set_fixed();
        snap_frame();
        pc = '0; ir = '0; cout = 1'b0; z = 1'b0; n = 1'b0;
        for (int k = 0; k < 8; k++) rv[k] = '0;
        wait_done();

        // snap during byte 7 is ignored.
        set_random();
        snap_frame();
        repeat (290) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        wait_done();
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (busy) seen = 1'b1;
        end
        check("no_second_frame", seen, 0);

        // snap held high: two frames with one idle cycle between them.
        set_random();
        snap = 1'b1;
        push_frame();
        push_frame();
        tick();
        acc = cyc;
        check("hold_busy1", busy, 1);
        wait_done();
        check("b2b_busy", busy, 1);
        check("b2b_tx", tx, 0);
        acc  = cyc;
        snap = 1'b0;
        wait_done();

        // Reset during byte 10 data bits aborts the frame.
        set_random();
        snap_frame();
        repeat (407) tick();
        reset = 1'b1;
        tick();
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (900) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_flushed", sb.size(), 0);

        // Clean frame after the abort.
        set_random();
        snap_frame();
        wait_done();

        repeat (10) tick();
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
